// File: rtl/cpu_mul_seq_pkg.sv
// cpu_mul_seq_pkg: shared widths, state type and timing constants for the multiply sequencer (CPU_MUL_SEQ_HI_EN widens the datapath for the high word).
package cpu_mul_seq_pkg;
  localparam int DATA_W = 32;
  localparam int DIGIT_W = 4;
  localparam int N_ITER = DATA_W / DIGIT_W;
  localparam int CNT_W = $clog2(N_ITER);
  localparam int LATENCY = N_ITER + 2;
`ifdef CPU_MUL_SEQ_HI_EN
  localparam int PP_W = DATA_W + DIGIT_W;
  localparam int ACC_W = 2 * DATA_W;
`else
  localparam int PP_W = DATA_W;
  localparam int ACC_W = DATA_W;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/cpu_mul_seq_if.sv
// cpu_mul_seq_if: request/result bundle between the M-stage and the multiply sequencer (result_hi only with CPU_MUL_SEQ_HI_EN).
interface cpu_mul_seq_if;
  import cpu_mul_seq_pkg::*;
  logic start;
  logic abort;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic ready;
  logic busy;
  logic done;
  logic [DATA_W-1:0] result;
`ifdef CPU_MUL_SEQ_HI_EN
  logic [DATA_W-1:0] result_hi;
  modport master(output start, abort, src1, src2, input ready, busy, done, result, result_hi);
  modport slave(input start, abort, src1, src2, output ready, busy, done, result, result_hi);
`else
  modport master(output start, abort, src1, src2, input ready, busy, done, result);
  modport slave(input start, abort, src1, src2, output ready, busy, done, result);
`endif
endinterface

// File: rtl/cpu_mul_seq_cell.sv
// cpu_mul_seq_cell: registered unsigned DATA_W x DIGIT_W partial-product cell, PP_W result (wider with CPU_MUL_SEQ_HI_EN).
module cpu_mul_seq_cell
  import cpu_mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [PP_W-1:0]   p
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) p <= '0;
    else p <= PP_W'(a) * PP_W'(b);
endmodule

// File: rtl/cpu_mul_seq.sv
// cpu_mul_seq: iterative 32x32 multiply sequencer driving one digit-serial cell; CPU_MUL_SEQ_HI_EN adds the high product word.
module cpu_mul_seq
  import cpu_mul_seq_pkg::*;
(
  input logic clk,
  input logic reset_n,
  cpu_mul_seq_if.slave bus
);
  state_t st, nxt;
  logic [DATA_W-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [PP_W-1:0] pp;
  logic [DIGIT_W-1:0] slice;
  logic accept, acc_en;
  assign accept = bus.start && (st == IDLE || st == DONE);
  assign slice = DIGIT_W'(b_q >> (DIGIT_W * int'(cnt)));
  // the cell result lags the issue by one cycle, so its weight comes from cnt_d
  assign acc_nxt = acc + (ACC_W'(pp) << (DIGIT_W * int'(cnt_d)));
  assign acc_en = (st == RUN && cnt != '0) || st == DRAIN;
  always_comb begin
    nxt = st;
    nxt = st == IDLE  ? (bus.start ? RUN : IDLE) :
          st == RUN   ? (bus.abort ? IDLE : cnt == CNT_W'(N_ITER - 1) ? DRAIN : RUN) :
          st == DRAIN ? (bus.abort ? IDLE : DONE) :
                        (bus.start ? RUN : IDLE);
  end
  cpu_mul_seq_cell u_cell (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a_q),
    .b       (slice),
    .p       (pp)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      bus.ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
`ifdef CPU_MUL_SEQ_HI_EN
      bus.result_hi <= '0;
`endif
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
      cnt_d <= '0;
    end else begin
      st <= nxt;
      bus.ready <= nxt == IDLE || nxt == DONE;
      bus.busy <= nxt == RUN || nxt == DRAIN;
      bus.done <= nxt == DONE;
      cnt_d <= cnt;
      if (accept) begin
        a_q <= bus.src1;
        b_q <= bus.src2;
        acc <= '0;
        cnt <= '0;
      end else begin
        if (st == RUN) cnt <= cnt + CNT_W'(1);
        if (acc_en) acc <= acc_nxt;
      end
      if (st == DRAIN && !bus.abort) begin
        bus.result <= acc_nxt[DATA_W-1:0];
`ifdef CPU_MUL_SEQ_HI_EN
        bus.result_hi <= acc_nxt[ACC_W-1:DATA_W];
`endif
      end
    end
endmodule

// File: tb/tb_cpu_mul_seq.sv
// tb_cpu_mul_seq: randomized and directed scoreboard bench for cpu_mul_seq against a 64-bit arithmetic reference.
module tb_cpu_mul_seq;
  import cpu_mul_seq_pkg::*;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_lo = '0;
  exp_t sb[$];
  cpu_mul_seq_if bus ();
  cpu_mul_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    exp_t e;
    p = {32'b0, a} * {32'b0, b};
    e.lo = p[31:0];
    e.hi = p[63:32];
    e.cyc = cyc + LATENCY;
    sb.push_back(e);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", {63'b0, bus.ready}, 64'd1);
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit exp_done);
    wait_ready();
    bus.src1 = a;
    bus.src2 = b;
    bus.start = 1'b1;
    if (exp_done) push(a, b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  always @(negedge clk)
    if (reset_n && bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {32'b0, bus.result}, {32'b0, e.lo});
`ifdef CPU_MUL_SEQ_HI_EN
        chk("result_hi", {32'b0, bus.result_hi}, {32'b0, e.hi});
`endif
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("ready_at_done", {63'b0, bus.ready}, 64'd1);
      end
      last_lo = bus.result;
    end
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.src1 = '0;
    bus.src2 = '0;
    #12;
    chk("rst_ready", {63'b0, bus.ready}, 64'd1);
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_done", {63'b0, bus.done}, 64'd0);
    chk("rst_result", {32'b0, bus.result}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(32'd3, 32'd5, 1'b1);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    // start held high across the whole run: only the DONE cycle may accept it again
    wait_ready();
    bus.src1 = 32'h12345678;
    bus.src2 = 32'h9ABCDEF0;
    bus.start = 1'b1;
    push(bus.src1, bus.src2);
    repeat (LATENCY) @(negedge clk);
    push(bus.src1, bus.src2);
    @(negedge clk);
    bus.start = 1'b0;
    issue(32'd7, 32'd6, 1'b1);
    repeat (LATENCY - 1) @(negedge clk);
    issue(32'h10000, 32'h10000, 1'b1);
    // abort four cycles after the start
    wait_ready();
    bus.src1 = 32'd2;
    bus.src2 = 32'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_ready", {63'b0, bus.ready}, 64'd1);
    chk("abort_busy", {63'b0, bus.busy}, 64'd0);
    chk("abort_result_kept", {32'b0, bus.result}, {32'b0, last_lo});
    issue(32'd9, 32'd9, 1'b1);
    // asynchronous reset in the middle of an operation
    issue(32'hDEAD, 32'hBEEF, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready", {63'b0, bus.ready}, 64'd1);
    chk("arst_busy", {63'b0, bus.busy}, 64'd0);
    chk("arst_done", {63'b0, bus.done}, 64'd0);
    chk("arst_result", {32'b0, bus.result}, 64'd0);
`ifdef CPU_MUL_SEQ_HI_EN
    chk("arst_result_hi", {32'b0, bus.result_hi}, 64'd0);
`endif
    last_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(32'd4, 32'd4, 1'b1);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = (i % 6 == 0) ? 32'hFFFFFFFF : $urandom;
      b = (i % 5 == 0) ? 32'h80000000 : $urandom;
      issue(a, b, 1'b1);
      // a start while busy must be ignored
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        if (bus.busy) begin
          bus.src1 = $urandom;
          bus.src2 = $urandom;
          bus.start = 1'b1;
          @(negedge clk);
          bus.start = 1'b0;
        end
      end
      if ($urandom_range(0, 2) == 0) repeat (LATENCY) @(negedge clk);
    end
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
